// File: rtl/alu_functional_unit.sv
// Integer ALU between RS and ROB: non-MUL ops 1 cycle, MUL MUL_LATENCY+1 cycles; result held until ROB ready, flush wins.
// Define ALU_FU_MUL_EN to build the multiplier; without it MUL completes in 1 cycle and returns zero.
package alu_functional_unit_pkg;
  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 6;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_LSL, ALU_LSR, ALU_ASR, ALU_MUL
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
endpackage

module alu_functional_unit
  import alu_functional_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rs_valid,
  input  alu_op_t                 in_rs_op,
  input  logic [GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  input  logic                    in_rs_set_nzcv,
  input  nzcv_t                   in_rs_nzcv,
  output logic                    out_rs_ready,
  input  logic                    in_rob_ready,
  input  logic                    in_rob_is_mispred,
  output logic                    out_rob_valid,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic                    out_rob_set_nzcv,
  output nzcv_t                   out_rob_nzcv
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

`ifdef ALU_FU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam logic [3:0] LAT_LAST = 4'(MUL_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  alu_op_t                 op_q, op_d;
  logic [GPR_SIZE-1:0]     a_q, a_d;
  logic [GPR_SIZE-1:0]     b_q, b_d;
  logic [ROB_IDX_SIZE-1:0] tag_q, tag_d;
  logic                    set_q, set_d;
  nzcv_t                   nzcv_q, nzcv_d;

  logic rs_ready;
  logic accept;

  // A flush blocks acceptance outright so a squashed entry can never slip in.
  assign rs_ready = !in_rob_is_mispred &&
                    ((state_q == IDLE) || ((state_q == DONE) && in_rob_ready));
  assign accept   = in_rs_valid && rs_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    set_d   = set_q;
    nzcv_d  = nzcv_q;
    if (in_rob_is_mispred) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        EXEC: begin
          if (cnt_q == LAT_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DONE: if (in_rob_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (accept) begin
        op_d    = in_rs_op;
        a_d     = in_rs_val_a;
        b_d     = in_rs_val_b;
        tag_d   = in_rs_dst_rob_index;
        set_d   = in_rs_set_nzcv;
        nzcv_d  = in_rs_nzcv;
        cnt_d   = '0;
        state_d = (MUL_EN && (in_rs_op == ALU_MUL)) ? EXEC : DONE;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      set_q   <= 1'b0;
      nzcv_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      nzcv_q  <= nzcv_d;
    end
  end

  // Result is a function of the latched operands only, so it stays stable while DONE stalls.
  logic [GPR_SIZE:0]   add_full;
  logic [GPR_SIZE:0]   sub_full;
  logic [GPR_SIZE-1:0] mul_res;
  logic [GPR_SIZE-1:0] res;
  logic [5:0]          shamt;
  nzcv_t               flags;

  assign shamt    = b_q[5:0];
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} + {1'b0, ~b_q} + (GPR_SIZE+1)'(1);
`ifdef ALU_FU_MUL_EN
  assign mul_res  = a_q * b_q;
`else
  assign mul_res  = '0;
`endif

  always_comb begin
    res   = '0;
    flags = nzcv_q;
    case (op_q)
      ALU_ADD: begin
        res     = add_full[GPR_SIZE-1:0];
        flags.c = add_full[GPR_SIZE];
        flags.v = (a_q[GPR_SIZE-1] == b_q[GPR_SIZE-1]) &&
                  (add_full[GPR_SIZE-1] != a_q[GPR_SIZE-1]);
      end
      ALU_SUB: begin
        res     = sub_full[GPR_SIZE-1:0];
        flags.c = sub_full[GPR_SIZE];
        flags.v = (a_q[GPR_SIZE-1] != b_q[GPR_SIZE-1]) &&
                  (sub_full[GPR_SIZE-1] != a_q[GPR_SIZE-1]);
      end
      ALU_AND: begin res = a_q & b_q; flags.c = 1'b0; flags.v = 1'b0; end
      ALU_ORR: begin res = a_q | b_q; flags.c = 1'b0; flags.v = 1'b0; end
      ALU_EOR: begin res = a_q ^ b_q; flags.c = 1'b0; flags.v = 1'b0; end
      ALU_LSL: res = a_q << shamt;
      ALU_LSR: res = a_q >> shamt;
      ALU_ASR: res = $unsigned($signed(a_q) >>> shamt);
      ALU_MUL: res = mul_res;
      default: res = '0;
    endcase
    flags.n = res[GPR_SIZE-1];
    flags.z = (res == '0);
  end

  assign out_rs_ready          = rs_ready;
  assign out_rob_valid         = (state_q == DONE);
  assign out_rob_dst_rob_index = tag_q;
  assign out_rob_value         = res;
  assign out_rob_set_nzcv      = set_q;
  assign out_rob_nzcv          = set_q ? flags : nzcv_q;

endmodule

// File: tb/tb_alu_functional_unit.sv
// Bench for alu_functional_unit: directed corner cases plus randomized ops scored against an arithmetic reference model.
module tb_alu_functional_unit;
  import alu_functional_unit_pkg::*;

  localparam int LAT = 4;
`ifdef ALU_FU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  localparam int MUL_LAT_EXP = MUL_ON ? LAT + 1 : 1;

  logic                    in_clk = 1'b0;
  logic                    in_rst = 1'b0;
  logic                    in_rs_valid;
  alu_op_t                 in_rs_op;
  logic [63:0]             in_rs_val_a, in_rs_val_b;
  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index;
  logic                    in_rs_set_nzcv;
  nzcv_t                   in_rs_nzcv;
  logic                    out_rs_ready;
  logic                    in_rob_ready;
  logic                    in_rob_is_mispred;
  logic                    out_rob_valid;
  logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
  logic [63:0]             out_rob_value;
  logic                    out_rob_set_nzcv;
  nzcv_t                   out_rob_nzcv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 in_clk = ~in_clk;

  alu_functional_unit #(.MUL_LATENCY(LAT)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_rs_valid(in_rs_valid), .in_rs_op(in_rs_op),
    .in_rs_val_a(in_rs_val_a), .in_rs_val_b(in_rs_val_b),
    .in_rs_dst_rob_index(in_rs_dst_rob_index),
    .in_rs_set_nzcv(in_rs_set_nzcv), .in_rs_nzcv(in_rs_nzcv),
    .out_rs_ready(out_rs_ready),
    .in_rob_ready(in_rob_ready), .in_rob_is_mispred(in_rob_is_mispred),
    .out_rob_valid(out_rob_valid), .out_rob_dst_rob_index(out_rob_dst_rob_index),
    .out_rob_value(out_rob_value), .out_rob_set_nzcv(out_rob_set_nzcv),
    .out_rob_nzcv(out_rob_nzcv)
  );

  function automatic logic signed [127:0] sx(input logic [63:0] x);
    return {{64{x[63]}}, x};
  endfunction

  // Flags are derived from the mathematical meaning: carry as unsigned wrap, overflow as "does not fit in 64 signed bits".
  function automatic void ref_alu(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                                  input logic set, input nzcv_t fin,
                                  output logic [63:0] r, output nzcv_t f);
    logic c, v;
    int   sh;
    c  = fin.c;
    v  = fin.v;
    sh = int'(b[5:0]);
    case (op)
      ALU_ADD: begin r = a + b; c = (r < a);  v = (sx(a) + sx(b)) != sx(r); end
      ALU_SUB: begin r = a - b; c = (a >= b); v = (sx(a) - sx(b)) != sx(r); end
      ALU_AND: begin r = a & b; c = 1'b0; v = 1'b0; end
      ALU_ORR: begin r = a | b; c = 1'b0; v = 1'b0; end
      ALU_EOR: begin r = a ^ b; c = 1'b0; v = 1'b0; end
      ALU_LSL: r = a << sh;
      ALU_LSR: r = a >> sh;
      ALU_ASR: r = a[63] ? ~((~a) >> sh) : (a >> sh);
      default: r = MUL_ON ? a * b : 64'd0;
    endcase
    f = set ? nzcv_t'({r[63], r == 64'd0, c, v}) : fin;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 70));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic drive_idle();
    in_rs_valid = 1'b0; in_rs_op = ALU_ADD; in_rs_val_a = '0; in_rs_val_b = '0;
    in_rs_dst_rob_index = '0; in_rs_set_nzcv = 1'b0; in_rs_nzcv = '0;
    in_rob_ready = 1'b0; in_rob_is_mispred = 1'b0;
  endtask

  task automatic issue(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [ROB_IDX_SIZE-1:0] tag, input logic set, input nzcv_t nz,
                       output logic rdy);
    in_rs_valid = 1'b1; in_rs_op = op; in_rs_val_a = a; in_rs_val_b = b;
    in_rs_dst_rob_index = tag; in_rs_set_nzcv = set; in_rs_nzcv = nz;
    #1 rdy = out_rs_ready;
    @(posedge in_clk); #1;
    in_rs_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 1;
    while (out_rob_valid !== 1'b1 && cyc <= max) begin
      @(posedge in_clk); #1;
      cyc++;
    end
    if (out_rob_valid !== 1'b1) cyc = -1;
  endtask

  task automatic consume();
    in_rob_ready = 1'b1;
    @(posedge in_clk); #1;
    in_rob_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    in_rst = 1'b0;
    repeat (2) @(posedge in_clk);
    #1 in_rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got v=%b tag=%h val=%h set=%b nzcv=%b, want all zero",
                        out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv);
    end
    n_cmp++;
    if (out_rs_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rs_ready: got %b want 1", out_rs_ready); end
  endtask

  task automatic test_add_sub();
    logic rdy;
    in_rob_ready = 1'b1;
    issue(ALU_ADD, 64'd5, 64'd7, 6'd3, 1'b1, nzcv_t'(4'b0000), rdy);
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL add_accept: got ready %b want 1", rdy); end
    n_cmp++;
    if ({out_rob_valid, out_rob_value, out_rob_dst_rob_index, out_rob_nzcv} !== {1'b1, 64'd12, 6'd3, 4'b0000}) begin
      n_bad++; $display("FAIL add_5_7: got v=%b val=%h tag=%h nzcv=%b want v=1 val=c tag=3 nzcv=0000",
                        out_rob_valid, out_rob_value, out_rob_dst_rob_index, out_rob_nzcv);
    end
    @(posedge in_clk); #1;
    issue(ALU_SUB, 64'd1, 64'd2, 6'd1, 1'b1, nzcv_t'(4'b0000), rdy);
    n_cmp++;
    if ({out_rob_valid, out_rob_value, out_rob_nzcv} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000}) begin
      n_bad++; $display("FAIL sub_1_2: got v=%b val=%h nzcv=%b want v=1 val=ffffffffffffffff nzcv=1000",
                        out_rob_valid, out_rob_value, out_rob_nzcv);
    end
    @(posedge in_clk); #1;
    issue(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd2, 1'b1, nzcv_t'(4'b0000), rdy);
    n_cmp++;
    if ({out_rob_valid, out_rob_value, out_rob_nzcv} !== {1'b1, 64'h8000_0000_0000_0000, 4'b1001}) begin
      n_bad++; $display("FAIL add_overflow: got v=%b val=%h nzcv=%b want v=1 val=8000000000000000 nzcv=1001",
                        out_rob_valid, out_rob_value, out_rob_nzcv);
    end
    @(posedge in_clk); #1;
    in_rob_ready = 1'b0;
  endtask

  task automatic test_mul();
    logic rdy;
    int   cyc;
    in_rob_ready = 1'b1;
    issue(ALU_MUL, 64'd6, 64'd7, 6'd9, 1'b1, nzcv_t'(4'b0011), rdy);
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL mul_accept: got ready %b want 1", rdy); end
    n_cmp++;
    if (out_rs_ready !== !MUL_ON) begin
      n_bad++; $display("FAIL mul_busy_ready: got %b want %b", out_rs_ready, !MUL_ON);
    end
    wait_valid(LAT + 4, cyc);
    n_cmp++;
    if (cyc != MUL_LAT_EXP) begin n_bad++; $display("FAIL mul_latency: got %0d want %0d", cyc, MUL_LAT_EXP); end
    n_cmp++;
    if ({out_rob_value, out_rob_nzcv} !== {(MUL_ON ? 64'd42 : 64'd0), (MUL_ON ? 4'b0011 : 4'b0111)}) begin
      n_bad++; $display("FAIL mul_6_7: got val=%h nzcv=%b want val=%h nzcv=%b", out_rob_value, out_rob_nzcv,
                        MUL_ON ? 64'd42 : 64'd0, MUL_ON ? 4'b0011 : 4'b0111);
    end
    @(posedge in_clk); #1;
    in_rob_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        rdy;
    logic [63:0] a1, b1, a2, b2, r1, r2;
    nzcv_t       f1, f2;
    a1 = pick(); b1 = pick(); a2 = pick(); b2 = pick();
    ref_alu(ALU_ADD, a1, b1, 1'b1, nzcv_t'(4'b0000), r1, f1);
    ref_alu(ALU_SUB, a2, b2, 1'b1, nzcv_t'(4'b0101), r2, f2);
    in_rob_ready = 1'b0;
    issue(ALU_ADD, a1, b1, 6'd5, 1'b1, nzcv_t'(4'b0000), rdy);
    in_rs_valid = 1'b1; in_rs_op = ALU_SUB; in_rs_val_a = a2; in_rs_val_b = b2;
    in_rs_dst_rob_index = 6'd6; in_rs_set_nzcv = 1'b1; in_rs_nzcv = nzcv_t'(4'b0101);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_nzcv, out_rs_ready} !==
          {1'b1, 6'd5, r1, f1, 1'b0}) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v=%b tag=%h val=%h nzcv=%b rdy=%b want v=1 tag=5 val=%h nzcv=%b rdy=0",
                          k, out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_nzcv, out_rs_ready, r1, f1);
      end
      @(posedge in_clk); #1;
    end
    in_rob_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_rs_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", out_rs_ready); end
    @(posedge in_clk); #1;
    in_rs_valid = 1'b0; in_rob_ready = 1'b0;
    n_cmp++;
    if ({out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_nzcv} !== {1'b1, 6'd6, r2, f2}) begin
      n_bad++; $display("FAIL b2b_result: got v=%b tag=%h val=%h nzcv=%b want v=1 tag=6 val=%h nzcv=%b",
                        out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_nzcv, r2, f2);
    end
    consume();
  endtask

  task automatic test_flush();
    logic rdy;
    int   seen;
    in_rob_ready = 1'b0;
    issue(ALU_MUL, 64'd3, 64'd4, 6'd8, 1'b0, nzcv_t'(4'b0000), rdy);
    @(posedge in_clk); #1;
    in_rob_is_mispred = 1'b1;
    in_rs_valid = 1'b1; in_rs_op = ALU_ADD; in_rs_val_a = 64'd1; in_rs_val_b = 64'd1; in_rs_dst_rob_index = 6'd7;
    #1;
    n_cmp++;
    if (out_rs_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", out_rs_ready); end
    @(posedge in_clk); #1;
    in_rob_is_mispred = 1'b0; in_rs_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_rob_valid, out_rs_ready} !== 2'b01) begin
      n_bad++; $display("FAIL flush_idle: got valid=%b ready=%b want valid=0 ready=1", out_rob_valid, out_rs_ready);
    end
    seen = 0;
    repeat (LAT + 4) begin
      @(posedge in_clk); #1;
      if (out_rob_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic rdy;
    int   seen;
    in_rob_ready = 1'b0;
    issue(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 6'd12, 1'b1, nzcv_t'(4'b1111), rdy);
    in_rst = 1'b0;
    @(posedge in_clk); #1;
    n_cmp++;
    if ({out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv} !== '0) begin
      n_bad++; $display("FAIL rst_done_outputs: got v=%b tag=%h val=%h set=%b nzcv=%b want all zero",
                        out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv);
    end
    in_rst = 1'b1;
    #1;
    n_cmp++;
    if (out_rs_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", out_rs_ready); end
    issue(ALU_MUL, 64'd9, 64'd9, 6'd4, 1'b1, nzcv_t'(4'b0000), rdy);
    in_rst = 1'b0;
    @(posedge in_clk); #1;
    in_rst = 1'b1;
    seen = 0;
    repeat (LAT + 3) begin
      @(posedge in_clk); #1;
      if (out_rob_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL rst_exec_discard: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_random();
    alu_op_t                 op;
    logic [63:0]             a, b, er;
    logic [ROB_IDX_SIZE-1:0] tag;
    logic                    set, rdy;
    nzcv_t                   nz, ef;
    int                      cyc, exp_lat, stall;
    for (int i = 0; i < 150; i++) begin
      op  = alu_op_t'(4'($urandom_range(0, 8)));
      a   = pick(); b = pick();
      tag = 6'($urandom_range(0, 63));
      set = 1'($urandom_range(0, 1));
      nz  = nzcv_t'(4'($urandom_range(0, 15)));
      ref_alu(op, a, b, set, nz, er, ef);
      exp_lat = (op == ALU_MUL) ? MUL_LAT_EXP : 1;
      issue(op, a, b, tag, set, nz, rdy);
      n_cmp++;
      if (rdy !== 1'b1) begin n_bad++; $display("FAIL rnd_accept[%0d]: got ready %b want 1", i, rdy); end
      wait_valid(LAT + 4, cyc);
      n_cmp++;
      if (cyc != exp_lat) begin n_bad++; $display("FAIL rnd_latency[%0d] op=%0d: got %0d want %0d", i, op, cyc, exp_lat); end
      stall = $urandom_range(0, 2);
      repeat (stall) begin @(posedge in_clk); #1; end
      n_cmp++;
      if ({out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv} !==
          {1'b1, tag, er, set, ef}) begin
        n_bad++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got v=%b tag=%h val=%h set=%b nzcv=%b want tag=%h val=%h set=%b nzcv=%b",
                          i, op, a, b, out_rob_valid, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv,
                          out_rob_nzcv, tag, er, set, ef);
      end
      consume();
      n_cmp++;
      if (out_rob_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_drain[%0d]: got valid %b want 0", i, out_rob_valid); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
